// File: rtl/adpll_ctrl_pkg.sv
// Shared constants for the ADPLL supervisory controller: state encoding and
// the default loop gains, also used by the top level and the RingADPLL instance.
package adpll_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ACQUIRE = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_TRACK   = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESTART = 3'd4;

  localparam int unsigned KP_WIDTH_DEF = 6;
  localparam int unsigned KI_WIDTH_DEF = 9;

  // kp has 5 fractional bits, ki has 8
  localparam logic [KP_WIDTH_DEF-1:0] KP_ACQ_DEF = 6'd18;
  localparam logic [KI_WIDTH_DEF-1:0] KI_ACQ_DEF = 9'd4;
  localparam logic [KP_WIDTH_DEF-1:0] KP_TRK_DEF = 6'd9;
  localparam logic [KI_WIDTH_DEF-1:0] KI_TRK_DEF = 9'd1;

endpackage

// File: rtl/ref_edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a rising-edge detect.
// Ports: clk, rst_n (synchronous, active-low), din (async level),
//        rise_c (one-cycle pulse, combinational from flops).
module ref_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise_c = sync & ~sync_d;

endmodule

// File: rtl/adpll_gain_scheduler.sv
// Supervisory gain scheduler for the ring ADPLL: sequences acquire / settle /
// track with wide then narrow gains, declares lock/unlock from the phase error
// and restarts the loop on acquisition timeout.
// Ports: fpga_clk_i, reset_n_i (sync, active-low), enable_i, ref_clk_i (async),
//        error_i (signed) in; adpll_enable_o, kp_o, ki_o, locked_o,
//        timeout_o (1-cycle pulse), state_o out. All outputs registered.
module adpll_gain_scheduler
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned ERR_WIDTH      = 8,
  parameter int unsigned KP_WIDTH       = KP_WIDTH_DEF,
  parameter int unsigned KI_WIDTH       = KI_WIDTH_DEF,
  parameter logic [KP_WIDTH-1:0] KP_ACQ = KP_WIDTH'(KP_ACQ_DEF),
  parameter logic [KI_WIDTH-1:0] KI_ACQ = KI_WIDTH'(KI_ACQ_DEF),
  parameter logic [KP_WIDTH-1:0] KP_TRK = KP_WIDTH'(KP_TRK_DEF),
  parameter logic [KI_WIDTH-1:0] KI_TRK = KI_WIDTH'(KI_TRK_DEF),
  parameter int unsigned LOCK_THRESH    = 3,
  parameter int unsigned UNLOCK_THRESH  = 12,
  parameter int unsigned LOCK_COUNT     = 64,
  parameter int unsigned UNLOCK_COUNT   = 8,
  parameter int unsigned SETTLE_EDGES   = 32,
  parameter int unsigned ACQ_TIMEOUT    = 4096,
  parameter int unsigned RESTART_CYCLES = 16
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_n_i,
  input  logic                 enable_i,
  input  logic                 ref_clk_i,
  input  logic [ERR_WIDTH-1:0] error_i,
  output logic                 adpll_enable_o,
  output logic [KP_WIDTH-1:0]  kp_o,
  output logic [KI_WIDTH-1:0]  ki_o,
  output logic                 locked_o,
  output logic                 timeout_o,
  output logic [STATE_W-1:0]   state_o
);

  localparam int unsigned AW    = ERR_WIDTH - 1;
  localparam int unsigned LCK_W = $clog2(LOCK_COUNT) + 1;
  localparam int unsigned UNL_W = $clog2(UNLOCK_COUNT) + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_EDGES) + 1;
  localparam int unsigned TMO_W = $clog2(ACQ_TIMEOUT) + 1;
  localparam int unsigned RST_W = $clog2(RESTART_CYCLES) + 1;

  logic                 ref_tick_c;
  logic [ERR_WIDTH-1:0] neg_err_c;
  logic [AW-1:0]        abs_err_c;
  logic                 in_lock_c;
  logic                 out_lock_c;

  logic [STATE_W-1:0] state, state_nxt;
  logic [LCK_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic [UNL_W-1:0]   unlock_cnt, unlock_cnt_nxt;
  logic [SET_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
  logic [RST_W-1:0]   rst_cnt, rst_cnt_nxt;

  logic                enable_nxt;
  logic [KP_WIDTH-1:0] kp_nxt;
  logic [KI_WIDTH-1:0] ki_nxt;
  logic                locked_nxt;
  logic                timeout_nxt;

  ref_edge_sync u_ref_sync (
    .clk    (fpga_clk_i),
    .rst_n  (reset_n_i),
    .din    (ref_clk_i),
    .rise_c (ref_tick_c)
  );

  // Saturating magnitude: the most negative code maps to all-ones
  always_comb begin
    neg_err_c = ~error_i + ERR_WIDTH'(1);
    abs_err_c = error_i[AW-1:0];
    if (error_i[ERR_WIDTH-1]) begin
      if (neg_err_c[ERR_WIDTH-1]) abs_err_c = '1;
      else                        abs_err_c = neg_err_c[AW-1:0];
    end
  end

  assign in_lock_c  = (abs_err_c <= AW'(LOCK_THRESH));
  assign out_lock_c = (abs_err_c >  AW'(UNLOCK_THRESH));

  // State and counter registers
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      state      <= ST_IDLE;
      lock_cnt   <= '0;
      unlock_cnt <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      rst_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      lock_cnt   <= lock_cnt_nxt;
      unlock_cnt <= unlock_cnt_nxt;
      settle_cnt <= settle_cnt_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      rst_cnt    <= rst_cnt_nxt;
    end
  end

  // Next state and counters; counters saturate and clear on any state change
  always_comb begin
    state_nxt      = state;
    lock_cnt_nxt   = lock_cnt;
    unlock_cnt_nxt = unlock_cnt;
    settle_cnt_nxt = settle_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    rst_cnt_nxt    = rst_cnt;
    case (state)
      ST_IDLE: begin
        if (enable_i) state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (ref_tick_c) begin
          tmo_cnt_nxt = (tmo_cnt == TMO_W'(ACQ_TIMEOUT)) ? tmo_cnt : tmo_cnt + TMO_W'(1);
          if (in_lock_c)
            lock_cnt_nxt = (lock_cnt == LCK_W'(LOCK_COUNT)) ? lock_cnt : lock_cnt + LCK_W'(1);
          else
            lock_cnt_nxt = '0;
          // lock takes precedence over a simultaneous timeout
          if (lock_cnt_nxt == LCK_W'(LOCK_COUNT))     state_nxt = ST_SETTLE;
          else if (tmo_cnt_nxt == TMO_W'(ACQ_TIMEOUT)) state_nxt = ST_RESTART;
        end
      end
      ST_SETTLE: begin
        if (ref_tick_c) begin
          settle_cnt_nxt = (settle_cnt == SET_W'(SETTLE_EDGES)) ? settle_cnt
                                                                 : settle_cnt + SET_W'(1);
          if (settle_cnt_nxt == SET_W'(SETTLE_EDGES)) state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (ref_tick_c) begin
          if (out_lock_c)
            unlock_cnt_nxt = (unlock_cnt == UNL_W'(UNLOCK_COUNT)) ? unlock_cnt
                                                                   : unlock_cnt + UNL_W'(1);
          else
            unlock_cnt_nxt = '0;
          if (unlock_cnt_nxt == UNL_W'(UNLOCK_COUNT)) state_nxt = ST_ACQUIRE;
        end
      end
      ST_RESTART: begin
        rst_cnt_nxt = (rst_cnt == RST_W'(RESTART_CYCLES)) ? rst_cnt : rst_cnt + RST_W'(1);
        if (rst_cnt_nxt == RST_W'(RESTART_CYCLES)) state_nxt = ST_ACQUIRE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // dropping the run request overrides every other transition
    if (!enable_i) state_nxt = ST_IDLE;
    if (state_nxt != state) begin
      lock_cnt_nxt   = '0;
      unlock_cnt_nxt = '0;
      settle_cnt_nxt = '0;
      tmo_cnt_nxt    = '0;
      rst_cnt_nxt    = '0;
    end
  end

  // Output values follow the upcoming state so gains move with the transition
  always_comb begin
    enable_nxt  = 1'b0;
    kp_nxt      = KP_ACQ;
    ki_nxt      = KI_ACQ;
    locked_nxt  = 1'b0;
    timeout_nxt = (state == ST_ACQUIRE) && (state_nxt == ST_RESTART);
    case (state_nxt)
      ST_ACQUIRE: enable_nxt = 1'b1;
      ST_SETTLE: begin
        enable_nxt = 1'b1;
        kp_nxt     = KP_TRK;
        ki_nxt     = KI_TRK;
      end
      ST_TRACK: begin
        enable_nxt = 1'b1;
        kp_nxt     = KP_TRK;
        ki_nxt     = KI_TRK;
        locked_nxt = 1'b1;
      end
      default: enable_nxt = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      adpll_enable_o <= 1'b0;
      kp_o           <= KP_ACQ;
      ki_o           <= KI_ACQ;
      locked_o       <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      adpll_enable_o <= enable_nxt;
      kp_o           <= kp_nxt;
      ki_o           <= ki_nxt;
      locked_o       <= locked_nxt;
      timeout_o      <= timeout_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: doc/adpll_gain_scheduler.md
Name: adpll_gain_scheduler

Overview:
- Supervisory controller for the ring ADPLL. It drives the loop's dynamic kp/ki inputs and its enable.
- Sequences the loop through acquisition with wide gains, a settle interval, and tracking with narrow gains.
- Monitors the signed phase error to declare lock and loss of lock. On acquisition timeout it restarts the loop.
- Sits beside the ADPLL in the top level, in the 258 MHz fabric clock domain. It replaces the switch-driven gain selection.

Parameters:
- ERR_WIDTH, 8, width of signed phase error from the ADPLL
- KP_WIDTH, 6, kp word width (5 fractional bits)
- KI_WIDTH, 9, ki word width (8 fractional bits)
- KP_ACQ, 6'd18, kp during ACQUIRE
- KI_ACQ, 9'd4, ki during ACQUIRE
- KP_TRK, 6'd9, kp during SETTLE/TRACK
- KI_TRK, 9'd1, ki during SETTLE/TRACK
- LOCK_THRESH, 3, abs(error) at or below this value counts as in-lock
- UNLOCK_THRESH, 12, abs(error) above this value counts as out-of-lock
- LOCK_COUNT, 64, consecutive in-lock ref edges required to leave ACQUIRE
- UNLOCK_COUNT, 8, consecutive out-of-lock ref edges in TRACK before declaring loss
- SETTLE_EDGES, 32, ref edges spent in SETTLE
- ACQ_TIMEOUT, 4096, ref edges allowed in ACQUIRE before restart
- RESTART_CYCLES, 16, fabric cycles the ADPLL is held disabled on restart

Ports:
- fpga_clk_i  in  1  fabric clock (258 MHz)
- reset_n_i  in  1  reset; one clock; reset is synchronous and active-low
- enable_i  in  1  run request (switch)
- ref_clk_i  in  1  external reference, asynchronous
- error_i  in  ERR_WIDTH  signed phase error from the ADPLL
- adpll_enable_o  out  1  ADPLL enable
- kp_o  out  KP_WIDTH  ADPLL kp
- ki_o  out  KI_WIDTH  ADPLL ki
- locked_o  out  1  lock indication
- timeout_o  out  1  one-cycle pulse on acquisition timeout
- state_o  out  3  current state, for LEDs/debug

Behaviour:
- Reset (reset_n_i low at a clock edge) forces the following; all outputs are registered:
  - state IDLE, adpll_enable_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ
  - locked_o=0, timeout_o=0
  - all counters 0, synchronizer flops 0
  - Reset mid-operation has the same effect.
- ref_clk_i passes through a 2-FF synchronizer plus a rising-edge detect, giving ref_tick, a single-cycle pulse.
  - error_i is sampled on the ref_tick cycle.
  - Latency from the ref pin edge to the sample is 3 fabric cycles.
- abs_err is computed as |error_i| in ERR_WIDTH-1 bits, saturating: -128 maps to 127.
- State encoding: IDLE=0, ACQUIRE=1, SETTLE=2, TRACK=3, RESTART=4.
- IDLE:
  - enable_o=0, gains ACQ.
  - If enable_i=1, go to ACQUIRE next cycle; counters are cleared.
- ACQUIRE:
  - enable_o=1, gains ACQ, locked_o=0.
  - On each ref_tick: the timeout counter increments. If abs_err<=LOCK_THRESH, lock_cnt increments; otherwise lock_cnt clears.
  - If lock_cnt reaches LOCK_COUNT, go to SETTLE.
  - Otherwise, if the timeout counter reaches ACQ_TIMEOUT, go to RESTART and pulse timeout_o for one cycle.
  - If both conditions occur on the same tick, lock wins.
- SETTLE:
  - Gains switch to TRK on the same cycle as the state change. enable_o=1.
  - After SETTLE_EDGES ref_ticks, go to TRACK; locked_o goes to 1 on entry.
  - Error is not evaluated in SETTLE.
- TRACK:
  - Gains TRK, locked_o=1.
  - On each ref_tick: if abs_err>UNLOCK_THRESH, unlock_cnt increments; otherwise it clears.
  - When unlock_cnt reaches UNLOCK_COUNT, go to ACQUIRE: locked_o=0, gains ACQ, counters cleared.
- RESTART:
  - adpll_enable_o=0, which resets the ADPLL's internal integrator.
  - Counts RESTART_CYCLES fabric cycles (ref_ticks ignored), then goes to ACQUIRE with counters cleared.
- enable_i=0 in any non-IDLE state goes to IDLE on the next cycle, with locked_o=0 and gains ACQ. This has priority over all other transitions.
- Counters saturate at their terminal value and never wrap. Each counter is sized with $clog2 of its terminal value plus 1.
- Gain changes occur only on state transitions, never mid-state.

Decomposition:
- Package adpll_ctrl_pkg holds:
  - the state encoding localparams
  - default gain constants, shared with the top level and the RingADPLL instantiation
- Sub-module ref_edge_sync: 2-FF synchronizer plus rising-edge pulse. It is also reusable for the phase-detector reference path.

Test Plan (LOCK_COUNT=4, UNLOCK_COUNT=2, SETTLE_EDGES=2, ACQ_TIMEOUT=10, RESTART_CYCLES=4; ref period 20 fabric cycles):
- Reset and enable:
  - Hold reset_n_i low for 3 cycles with enable_i=1 -> outputs equal reset values, state_o=0.
  - Release reset -> state_o=1 one cycle later, adpll_enable_o=1, kp_o=18, ki_o=4.
- Lock acquisition: error_i=2 constant -> SETTLE after the 4th ref_tick with kp_o=9, ki_o=1; TRACK and locked_o=1 after 2 further ticks.
- Lock counter clear: error sequence 1,1,1,-20,1,1,1,1 -> SETTLE only after the 8th tick. error=-128 must count as abs 127, not in-lock.
- Acquisition timeout: error_i=50 constant -> timeout_o pulses once at the 10th tick, adpll_enable_o=0 for exactly 4 cycles, then ACQUIRE with gains ACQ.
- Loss of lock: in TRACK, error sequence 20,5,20,20 -> stays locked after ticks 1-3; at tick 4, locked_o=0, state ACQUIRE, kp_o=18.
- Enable drop: deassert enable_i mid-SETTLE (or with ref_tick coincident with the lock count) -> IDLE next cycle, adpll_enable_o=0, locked_o=0, kp_o=18.
